// File: rtl/wt_fetch_ctrl.sv
// Weight ROM fetch sequencer: reads word pairs from a dual-port ROM and streams them over valid/ready.
// Define WT_FETCH_PERF_EN to add the perf_stall back-pressure cycle counter.
module wt_fetch_ctrl #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 144,
    parameter int unsigned DEPTH      = 76
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic                  wt_valid,
    input  logic                  wt_ready,
    output logic [DATA_WIDTH-1:0] wt_data_a,
    output logic [DATA_WIDTH-1:0] wt_data_b,
    output logic                  wt_b_vld,
    output logic                  wt_last
`ifdef WT_FETCH_PERF_EN
    ,
    output logic [15:0]           perf_stall
`endif
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_t;

    typedef struct packed {
        logic                  vld;
        logic                  bv;
        logic                  last;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } ent_t;

    localparam logic [ADDR_WIDTH-1:0] One       = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] Two       = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] AddrLast  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] AddrLast2 = ADDR_WIDTH'(DEPTH - 2);

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr, rem, src_ptr, src_rem, ptr_p1, ptr_p2;
    logic                  iss1, iss2, bv1, bv2, last1, last2;
    logic                  start_ok, issue, pop, push;
    logic [1:0]            cnt, wr_idx;
    logic [2:0]            pending;

    // slot[0] is the output register; slots 1-2 form the FIFO behind it
    ent_t slot [3];
    ent_t slot_nxt [3];

    assign start_ok = start && (state == StIdle || state == StDone);
    assign pop      = slot[0].vld && wt_ready;
    assign push     = iss2;
    assign cnt      = 2'(slot[0].vld) + 2'(slot[1].vld) + 2'(slot[2].vld);
    // Entries that will occupy the buffer once all outstanding reads land
    assign pending  = 3'(cnt) + 3'(iss1) + 3'(iss2) - 3'(pop);

    // First pair is issued on the same edge the start is accepted
    assign src_ptr = start_ok ? cfg_base : ptr;
    assign src_rem = start_ok ? cfg_len : rem;
    assign issue   = start_ok ? (cfg_len != '0)
                              : (state == StFetch && rem != '0 && pending < 3'd3);
    assign ptr_p1  = (src_ptr == AddrLast) ? '0 : src_ptr + One;
    assign ptr_p2  = (src_ptr >= AddrLast2) ? src_ptr - AddrLast2 : src_ptr + Two;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            busy   <= 1'b0;
            done   <= 1'b0;
            ptr    <= '0;
            rem    <= '0;
            addr_a <= '0;
            addr_b <= '0;
            iss1   <= 1'b0;
            iss2   <= 1'b0;
            bv1    <= 1'b0;
            bv2    <= 1'b0;
            last1  <= 1'b0;
            last2  <= 1'b0;
        end else begin
            done  <= 1'b0;
            iss1  <= issue;
            bv1   <= (src_rem != One);
            last1 <= (src_rem <= Two);
            iss2  <= iss1;
            bv2   <= bv1;
            last2 <= last1;
            if (issue) begin
                addr_a <= src_ptr;
                addr_b <= (src_rem == One) ? src_ptr : ptr_p1;
                ptr    <= ptr_p2;
                rem    <= (src_rem > Two) ? src_rem - Two : '0;
            end
            unique case (state)
                StIdle, StDone: begin
                    state <= StIdle;
                    // Zero-length runs go straight to DRAIN so busy still shows for a cycle
                    if (start_ok) begin
                        busy  <= 1'b1;
                        state <= (cfg_len > Two) ? StFetch : StDrain;
                    end
                end
                StFetch: if (issue && rem <= Two) state <= StDrain;
                StDrain: begin
                    if (pending == 3'd0) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        slot_nxt = slot;
        wr_idx   = cnt - 2'(pop);
        if (pop) begin
            slot_nxt[0] = slot[1];
            slot_nxt[1] = slot[2];
            slot_nxt[2] = '0;
        end
        if (push) begin
            slot_nxt[wr_idx].vld  = 1'b1;
            slot_nxt[wr_idx].bv   = bv2;
            slot_nxt[wr_idx].last = last2;
            slot_nxt[wr_idx].a    = q_a;
            slot_nxt[wr_idx].b    = bv2 ? q_b : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) slot[i] <= '0;
        end else begin
            slot <= slot_nxt;
        end
    end

    assign wt_valid  = slot[0].vld;
    assign wt_b_vld  = slot[0].bv;
    assign wt_last   = slot[0].last;
    assign wt_data_a = slot[0].a;
    assign wt_data_b = slot[0].b;

`ifdef WT_FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall <= '0;
        end else if (start_ok) begin
            perf_stall <= '0;
        end else if (wt_valid && !wt_ready && perf_stall != 16'hFFFF) begin
            perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wt_fetch_ctrl.sv
// Randomized bench for wt_fetch_ctrl with a queue-based beat model and a ROM model.
// Build with WT_FETCH_PERF_EN defined to also exercise perf_stall.
module tb_wt_fetch_ctrl;

    localparam int AW = 7;
    localparam int DW = 144;
    localparam int D  = 76;

    logic          clk = 1'b0;
    logic          rst, start, wt_ready;
    logic [AW-1:0] cfg_base, cfg_len, addr_a, addr_b;
    logic [DW-1:0] q_a, q_b, wt_data_a, wt_data_b;
    logic          busy, done, wt_valid, wt_b_vld, wt_last;
`ifdef WT_FETCH_PERF_EN
    logic [15:0]   perf_stall;
`endif

    wt_fetch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .busy      (busy),
        .done      (done),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .q_a       (q_a),
        .q_b       (q_b),
        .wt_valid  (wt_valid),
        .wt_ready  (wt_ready),
        .wt_data_a (wt_data_a),
        .wt_data_b (wt_data_b),
        .wt_b_vld  (wt_b_vld),
        .wt_last   (wt_last)
`ifdef WT_FETCH_PERF_EN
        ,
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_w(input int i);
        logic [31:0] h;
        h = 32'(i) * 32'h9E37_79B9 + 32'h0123_4567;
        return {16'(i), h, ~h, h ^ 32'hA5A5_A5A5, {h[15:0], h[31:16]}};
    endfunction

    always @(posedge clk) begin
        q_a <= rom_w(int'(addr_a));
        q_b <= rom_w(int'(addr_b));
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: expected beats per accepted run, busy/done derived from handshakes
    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          bv;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         nbt;
    logic          m_busy = 1'b0, m_done = 1'b0, zero_pend = 1'b0;
    logic          nb_busy, nb_done;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_a, prev_b;
    logic          prev_bv, prev_last;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_ctrl", {busy, done, wt_valid, wt_b_vld, wt_last, addr_a, addr_b}, '0);
            chk("reset_data", wt_data_a | wt_data_b, '0);
            exp_q.delete();
            m_busy     = 1'b0;
            m_done     = 1'b0;
            zero_pend  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (wt_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", wt_valid, 1'b0);
                end else begin
                    chk("data_a", wt_data_a, exp_q[0].a);
                    chk("data_b", wt_data_b, exp_q[0].b);
                    chk("b_vld", wt_b_vld, exp_q[0].bv);
                    chk("last", wt_last, exp_q[0].last);
                end
            end
            if (stall_prev) begin
                chk("stall_valid", wt_valid, 1'b1);
                chk("stall_data", {wt_data_a, wt_data_b} == {prev_a, prev_b}, 1'b1);
                chk("stall_tags", {wt_b_vld, wt_last}, {prev_bv, prev_last});
            end
            nb_busy = m_busy;
            nb_done = 1'b0;
            if (wt_valid && wt_ready && exp_q.size() > 0) begin
                if (exp_q[0].last) begin
                    nb_done = 1'b1;
                    nb_busy = 1'b0;
                end
                void'(exp_q.pop_front());
            end
            if (zero_pend) begin
                nb_done   = 1'b1;
                nb_busy   = 1'b0;
                zero_pend = 1'b0;
            end
            if (start && !m_busy) begin
                nb_busy = 1'b1;
                if (cfg_len == 0) zero_pend = 1'b1;
                for (int k = 0; k < (int'(cfg_len) + 1) / 2; k++) begin
                    nbt.a    = rom_w((int'(cfg_base) + 2 * k) % D);
                    nbt.bv   = (2 * k + 1 < int'(cfg_len));
                    nbt.b    = nbt.bv ? rom_w((int'(cfg_base) + 2 * k + 1) % D) : '0;
                    nbt.last = (k == (int'(cfg_len) + 1) / 2 - 1);
                    exp_q.push_back(nbt);
                end
            end
            stall_prev = wt_valid && !wt_ready;
            prev_a     = wt_data_a;
            prev_b     = wt_data_b;
            prev_bv    = wt_b_vld;
            prev_last  = wt_last;
            m_busy     = nb_busy;
            m_done     = nb_done;
        end
    end

    logic rmode = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rmode) wt_ready = ($urandom_range(0, 99) >= 30);
    endtask

    // Runs one transfer; inj >= 0 pulses a competing start at that cycle of the run
    task automatic run(input int base, input int len, input int inj, output int beats,
                       output int busy_cyc, output logic lbv, output logic [DW-1:0] lb,
                       output logic llast);
        int cyc;
        cfg_base = AW'(base);
        cfg_len  = AW'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        beats    = 0;
        busy_cyc = 0;
        cyc      = 0;
        lbv      = 1'bx;
        lb       = 'x;
        llast    = 1'bx;
        while (!done && cyc < 3000) begin
            if (busy) busy_cyc++;
            if (wt_valid && wt_ready) begin
                beats++;
                lbv   = wt_b_vld;
                lb    = wt_data_b;
                llast = wt_last;
            end
            if (cyc == inj) begin
                cfg_base = AW'(20);
                cfg_len  = AW'(3);
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL run_timeout: got done=0 expected done=1 within 3000 cycles");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    int            beats, bc, cnt, g, len;
    logic          lbv, llast;
    logic [DW-1:0] lb;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        cfg_base = '0;
        cfg_len  = '0;
        wt_ready = 1'b1;
        repeat (3) tick();
        chk("reset_busy_done", {busy, done, wt_valid}, 3'b000);
        rst = 1'b0;
        tick();

        // Full ROM sweep with ready held high
        cfg_base = '0;
        cfg_len  = AW'(76);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("t1_first_addr", {addr_a, addr_b}, {7'd0, 7'd1});
        chk("t1_valid_c1", wt_valid, 1'b0);
        tick();
        tick();
        chk("t1_valid_c3", wt_valid, 1'b1);
        cnt = 0;
        while (wt_valid && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("t1_beats", cnt, 38);
        chk("t1_done_next", done, 1'b1);
        tick();

        // Wrapping run with odd length
        run(70, 9, -1, beats, bc, lbv, lb, llast);
        chk("t2_beats", beats, 5);
        chk("t2_last_bvld", lbv, 1'b0);
        chk("t2_last_datab", lb, '0);
        chk("t2_last_flag", llast, 1'b1);
        chk("t2_addr_hold", {addr_a, addr_b}, {7'd2, 7'd2});
        tick();

        // Random back-pressure
        rmode = 1'b1;
        run(int'($urandom_range(0, 75)), 8, -1, beats, bc, lbv, lb, llast);
        chk("t3_beats", beats, 4);
        for (int r = 0; r < 12; r++) begin
            len = int'($urandom_range(0, 76));
            run(int'($urandom_range(0, 75)), len, -1, beats, bc, lbv, lb, llast);
            chk("rand_beats", beats, (len + 1) / 2);
            repeat ($urandom_range(0, 2)) tick();
        end
        rmode    = 1'b0;
        wt_ready = 1'b1;
        tick();

        // Zero length, then a start issued mid-run
        run(3, 0, -1, beats, bc, lbv, lb, llast);
        chk("t4_zero_beats", beats, 0);
        chk("t4_busy_cycles", bc, 1);
        tick();
        run(0, 76, 5, beats, bc, lbv, lb, llast);
        chk("t4_ignored_start", beats, 38);
        tick();
        tick();
        chk("t4_idle_after", busy, 1'b0);

        // Reset in the middle of a run
        cfg_base = AW'(5);
        cfg_len  = AW'(20);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cnt      = 0;
        g        = 0;
        while (cnt < 3 && g < 100) begin
            if (wt_valid && wt_ready) cnt++;
            tick();
            g++;
        end
        rst = 1'b1;
        #1;
        chk("t5_rst_ctrl", {busy, done, wt_valid, wt_b_vld, wt_last, addr_a, addr_b}, '0);
        chk("t5_rst_data", wt_data_a | wt_data_b, '0);
        tick();
        tick();
        rst = 1'b0;
        run(0, 4, -1, beats, bc, lbv, lb, llast);
        chk("t5_clean_beats", beats, 2);
        tick();

`ifdef WT_FETCH_PERF_EN
        cfg_base = '0;
        cfg_len  = AW'(4);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        g        = 0;
        while (!wt_valid && g < 20) begin
            tick();
            g++;
        end
        wt_ready = 1'b0;
        repeat (5) tick();
        wt_ready = 1'b1;
        while (!done && g < 100) begin
            tick();
            g++;
        end
        chk("t6_perf_done", perf_stall, 16'd5);
        tick();
        chk("t6_perf_hold", perf_stall, 16'd5);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
